// File: rtl/package_settings.sv
// rtl/package_settings.sv - shared shaper widths, peak sampler state and event types
package package_settings;

    localparam int SIZE_SHAPER_DATA     = 16;
    localparam int SIZE_SHAPER_CONSTANT = 8;
    localparam int SIZE_TIMESTAMP       = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TOP  = 2'd1,
        FLAT = 2'd2,
        PILE = 2'd3
    } peak_state_t;

    // Event layout at the default widths; the sampler packs the same field order.
    typedef struct packed {
        logic [SIZE_SHAPER_DATA-1:0] energy;
        logic                        pileup;
        logic [SIZE_TIMESTAMP-1:0]   time_stamp;
    } peak_evt_t;

endpackage

// File: rtl/peak_evt_reg.sv
// rtl/peak_evt_reg.sv - one-entry valid/ready event register with saturating lost counter
module peak_evt_reg
    import package_settings::*;
#(
    parameter int PAY_W  = SIZE_SHAPER_DATA + 1,
    parameter int LOST_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              emit,
    input  logic [PAY_W-1:0]  evt_in,
    input  logic              evt_ready,
    output logic              evt_valid,
    output logic [PAY_W-1:0]  evt_out,
    output logic [LOST_W-1:0] lost_cnt
);

    // Load on a free or draining slot, count a drop when the slot is stalled, else drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_valid <= 1'b0;
            evt_out   <= '0;
            lost_cnt  <= '0;
        end else if (emit && (!evt_valid || evt_ready)) begin
            evt_valid <= 1'b1;
            evt_out   <= evt_in;
        end else if (emit) begin
            if (lost_cnt != '1) begin
                lost_cnt <= lost_cnt + LOST_W'(1);
            end
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/trapez_peak_sampler.sv
// rtl/trapez_peak_sampler.sv - trapezoid peak sampler; TRAPEZ_PEAK_TIMESTAMP_EN adds evt_time
module trapez_peak_sampler
    import package_settings::*;
#(
    parameter int DATA_W  = SIZE_SHAPER_DATA,
    parameter int CONST_W = SIZE_SHAPER_CONSTANT,
    parameter int LOST_W  = 16
`ifdef TRAPEZ_PEAK_TIMESTAMP_EN
    ,
    parameter int TS_W    = SIZE_TIMESTAMP
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               pulse_time,
    input  logic [DATA_W-1:0]  shaper_data,
    input  logic [DATA_W-1:0]  threshold,
    input  logic [CONST_W-1:0] k_trapez,
    input  logic [CONST_W-1:0] l_trapez,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [DATA_W-1:0]  evt_energy,
    output logic               evt_pileup,
`ifdef TRAPEZ_PEAK_TIMESTAMP_EN
    output logic [TS_W-1:0]    evt_time,
`endif
    output logic [LOST_W-1:0]  lost_cnt
);

    localparam int CNT_W = CONST_W + 2;
`ifdef TRAPEZ_PEAK_TIMESTAMP_EN
    localparam int PAY_W = DATA_W + 1 + TS_W;
`else
    localparam int PAY_W = DATA_W + 1;
`endif

    logic signed [DATA_W-1:0] d_q;
    logic signed [DATA_W-1:0] d_prev;
    logic signed [DATA_W-1:0] thr_s;
    logic                     above_now;
    logic                     above_prev;
    logic                     crossing;
    logic [CNT_W-1:0]         sample_pt;
    logic [CNT_W-1:0]         max_w;
    logic [CNT_W-1:0]         cnt;
    logic [DATA_W-1:0]        energy_q;
    peak_state_t              state;
    peak_state_t              state_nxt;
    logic                     emit;
    logic                     take_sample;
    logic [PAY_W-1:0]         evt_payload;
    logic [PAY_W-1:0]         evt_held;

    assign thr_s      = $signed(threshold);
    assign above_now  = d_q >= thr_s;
    assign above_prev = d_prev >= thr_s;
    assign crossing   = above_now && !above_prev;

    assign sample_pt = CNT_W'(k_trapez) + CNT_W'(l_trapez >> 1);
    assign max_w     = (CNT_W'(k_trapez) << 1) + CNT_W'(l_trapez) + CNT_W'(2);

    // Two-deep sample history for the rising-edge threshold test.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_q    <= '0;
            d_prev <= '0;
        end else begin
            d_q    <= $signed(shaper_data);
            d_prev <= d_q;
        end
    end

    // Pulse tracking: gate/enable loss always wins, then fall, then sample point or timeout.
    always_comb begin
        state_nxt   = state;
        emit        = 1'b0;
        take_sample = 1'b0;
        if (!enable || !pulse_time) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (crossing) state_nxt = TOP;
                end
                TOP: begin
                    if (!above_now) begin
                        state_nxt = IDLE;
                    end else if (cnt == sample_pt) begin
                        take_sample = 1'b1;
                        state_nxt   = FLAT;
                    end
                end
                FLAT: begin
                    if (!above_now) begin
                        emit      = 1'b1;
                        state_nxt = IDLE;
                    end else if (cnt == max_w) begin
                        state_nxt = PILE;
                    end
                end
                PILE: begin
                    if (!above_now) begin
                        emit      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, offset counter (0 in the crossing cycle, saturating) and clamped energy latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            energy_q <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == IDLE) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (take_sample) begin
                energy_q <= d_q[DATA_W-1] ? '0 : $unsigned(d_q);
            end
        end
    end

`ifdef TRAPEZ_PEAK_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_q;

    // Free-running timestamp, captured when a crossing starts a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt <= '0;
            ts_q   <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (state == IDLE && state_nxt == TOP) begin
                ts_q <= ts_cnt;
            end
        end
    end

    assign evt_payload = {energy_q, (state == PILE), ts_q};
    assign evt_time    = evt_held[TS_W-1:0];
`else
    assign evt_payload = {energy_q, (state == PILE)};
`endif

    peak_evt_reg #(
        .PAY_W  (PAY_W),
        .LOST_W (LOST_W)
    ) u_evt_reg (
        .clk       (clk),
        .reset     (reset),
        .emit      (emit),
        .evt_in    (evt_payload),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_out   (evt_held),
        .lost_cnt  (lost_cnt)
    );

    assign evt_energy = evt_held[PAY_W-1 -: DATA_W];
    assign evt_pileup = evt_held[PAY_W-DATA_W-1];

endmodule

// File: tb/tb_trapez_peak_sampler.sv
// tb/tb_trapez_peak_sampler.sv - directed self-checking bench with a pulse-level event model
module tb_trapez_peak_sampler;
    import package_settings::*;

    localparam int MAXN = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        pulse_time;
    logic [15:0] shaper_data;
    logic [15:0] threshold;
    logic [7:0]  k_trapez;
    logic [7:0]  l_trapez;
    logic        evt_valid;
    logic        evt_ready;
    logic [15:0] evt_energy;
    logic        evt_pileup;
    logic [15:0] lost_cnt;
`ifdef TRAPEZ_PEAK_TIMESTAMP_EN
    logic [31:0] evt_time;
`endif

    always #5 clk = ~clk;

    trapez_peak_sampler dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pulse_time  (pulse_time),
        .shaper_data (shaper_data),
        .threshold   (threshold),
        .k_trapez    (k_trapez),
        .l_trapez    (l_trapez),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_energy  (evt_energy),
        .evt_pileup  (evt_pileup),
`ifdef TRAPEZ_PEAK_TIMESTAMP_EN
        .evt_time    (evt_time),
`endif
        .lost_cnt    (lost_cnt)
    );

    int checks = 0;
    int errors = 0;

    int smp[MAXN];
    int pt[MAXN];
    int en[MAXN];
    int rdy[MAXN];
    int rst[MAXN];
    int em[MAXN];
    peak_evt_t em_evt[MAXN];
    int exp_v[MAXN];
    int exp_e[MAXN];
    int exp_p[MAXN];
    int exp_l[MAXN];
    int obs_v[MAXN];
    int obs_e[MAXN];
    int obs_p[MAXN];
    int obs_l[MAXN];
    int thr;
    int kk;
    int ll;
    int nlen;
    int t1[12] = '{0, 50, 120, 200, 300, 400, 500, 500, 500, 500, 400, 0};

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int s(int i);
        if (i < 0 || i >= nlen) return 0;
        return smp[i];
    endfunction

    function automatic int gate(int c);
        return (en[c] != 0 && pt[c] != 0) ? 1 : 0;
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < MAXN; i++) begin
            smp[i] = 0; pt[i] = 1; en[i] = 1; rdy[i] = 1; rst[i] = 0;
        end
        thr = 100; kk = 4; ll = 4;
    endtask

    task automatic load_t1(int off);
        for (int i = 0; i < 12; i++) smp[off + i] = t1[i];
    endtask

    function automatic int count_valid(int from, int to);
        int n = 0;
        for (int c = from; c <= to; c++) n += obs_v[c];
        return n;
    endfunction

    // Pulse-level model: find crossings, falls and gate losses in sample space,
    // then play the emitted events through a one-slot holding register.
    task automatic run_model();
        int sp = kk + ll / 2;
        int mw = 2 * kk + ll + 2;
        int idle_from = 0;
        int n = 0;
        int v = 0, e = 0, p = 0, l = 0;
        for (int c = 0; c < MAXN; c++) begin
            em[c] = 0;
            em_evt[c] = '0;
        end
        while (n + 1 < nlen) begin
            if (n + 1 >= idle_from && s(n) >= thr && s(n - 1) < thr && gate(n + 1) != 0) begin
                int m = n + 1;
                int a = -1;
                while (m < nlen && s(m) >= thr) m++;
                for (int cc = n + 2; cc <= m + 1 && cc < nlen; cc++) begin
                    if (gate(cc) == 0) begin
                        a = cc;
                        break;
                    end
                end
                if (a >= 0) begin
                    idle_from = a + 1;
                    n = a;
                end else begin
                    if (m - n > sp && m + 1 < nlen) begin
                        em[m + 1] = 1;
                        em_evt[m + 1].energy = 16'((s(n + sp) < 0) ? 0 : s(n + sp));
                        em_evt[m + 1].pileup = (m - n > mw);
                    end
                    idle_from = m + 2;
                    n = m + 1;
                end
            end else begin
                n++;
            end
        end
        for (int c = 0; c < nlen; c++) begin
            exp_v[c] = v; exp_e[c] = e; exp_p[c] = p; exp_l[c] = l;
            if (em[c] != 0 && (v == 0 || rdy[c] != 0)) begin
                v = 1;
                e = int'(em_evt[c].energy);
                p = int'(em_evt[c].pileup);
            end else if (em[c] != 0) begin
                if (l < 65535) l++;
            end else if (v != 0 && rdy[c] != 0) begin
                v = 0;
            end
        end
    endtask

    task automatic run(string tname, bit use_model);
        if (use_model) run_model();
        threshold = 16'(thr); k_trapez = 8'(kk); l_trapez = 8'(ll);
        reset = 1'b1; shaper_data = '0; enable = 1'b1; pulse_time = 1'b1; evt_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int c = 0; c < nlen; c++) begin
            reset = rst[c][0]; shaper_data = 16'(smp[c]); enable = en[c][0];
            pulse_time = pt[c][0]; evt_ready = rdy[c][0];
            @(negedge clk);
            obs_v[c] = int'(evt_valid); obs_e[c] = int'(evt_energy);
            obs_p[c] = int'(evt_pileup); obs_l[c] = int'(lost_cnt);
            if (use_model) begin
                check($sformatf("%s c%0d valid", tname, c), obs_v[c], exp_v[c]);
                if (exp_v[c] != 0) begin
                    check($sformatf("%s c%0d energy", tname, c), obs_e[c], exp_e[c]);
                    check($sformatf("%s c%0d pileup", tname, c), obs_p[c], exp_p[c]);
                end
                check($sformatf("%s c%0d lost", tname, c), obs_l[c], exp_l[c]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // basic pulse
        clear_stim(); nlen = 20; load_t1(0);
        run("t1", 1);
        check("t1 model energy", exp_e[13], 500);
        check("t1 valid c12", obs_v[12], 0);
        check("t1 valid c13", obs_v[13], 1);
        check("t1 energy c13", obs_e[13], 500);
        check("t1 pileup c13", obs_p[13], 0);
        check("t1 drained c14", obs_v[14], 0);

        // long pulse -> pile-up
        clear_stim(); nlen = 32;
        for (int i = 2; i < 22; i++) smp[i] = 300;
        run("t2", 1);
        check("t2 model pileup", exp_p[24], 1);
        check("t2 valid c24", obs_v[24], 1);
        check("t2 energy c24", obs_e[24], 300);
        check("t2 pileup c24", obs_p[24], 1);

        // short pulse discarded
        clear_stim(); nlen = 12;
        for (int i = 2; i < 6; i++) smp[i] = 200;
        run("t3", 1);
        check("t3 no event", count_valid(0, 11), 0);
        check("t3 lost", obs_l[11], 0);

        // stalled consumer, back-to-back pulses
        clear_stim(); nlen = 30; load_t1(0);
        smp[12] = 150;
        for (int i = 13; i < 20; i++) smp[i] = 250;
        for (int i = 0; i < 30; i++) rdy[i] = 0;
        rdy[26] = 1;
        run("t4", 1);
        check("t4 lost c21", obs_l[21], 0);
        check("t4 lost c22", obs_l[22], 1);
        check("t4 held energy c25", obs_e[25], 500);
        check("t4 valid c26", obs_v[26], 1);
        check("t4 valid c27", obs_v[27], 0);

        // ready coincides with a new emit while one is pending
        clear_stim(); nlen = 30; load_t1(0);
        smp[12] = 150;
        for (int i = 13; i < 20; i++) smp[i] = 250;
        for (int i = 0; i < 30; i++) rdy[i] = 0;
        rdy[21] = 1;
        run("t5", 1);
        check("t5 energy c21", obs_e[21], 500);
        check("t5 valid c22", obs_v[22], 1);
        check("t5 energy c22", obs_e[22], 250);
        check("t5 lost c22", obs_l[22], 0);

        // pulse gate dropped in FLAT
        clear_stim(); nlen = 32;
        for (int i = 2; i < 22; i++) smp[i] = 300;
        pt[12] = 0;
        run("t6", 1);
        check("t6 no event", count_valid(0, 31), 0);

        // enable dropped in TOP
        clear_stim(); nlen = 20; load_t1(0);
        en[6] = 0;
        run("t7", 1);
        check("t7 no event", count_valid(0, 19), 0);

        // reset in FLAT with an event held, then a clean pulse
        clear_stim(); nlen = 46; load_t1(0);
        smp[14] = 150;
        for (int i = 15; i < 23; i++) smp[i] = 300;
        load_t1(28);
        for (int i = 0; i < 46; i++) rdy[i] = 0;
        rst[23] = 1;
        run("t8", 0);
        check("t8 held valid c22", obs_v[22], 1);
        check("t8 held energy c22", obs_e[22], 500);
        check("t8 reset valid", obs_v[24], 0);
        check("t8 reset energy", obs_e[24], 0);
        check("t8 reset pileup", obs_p[24], 0);
        check("t8 reset lost", obs_l[24], 0);
        check("t8 no event after reset", count_valid(24, 40), 0);
        check("t8 next valid c41", obs_v[41], 1);
        check("t8 next energy c41", obs_e[41], 500);

        // negative threshold, clamp to zero, other k/l
        clear_stim(); nlen = 14; thr = -50; kk = 2; ll = 2;
        smp[0] = -100; smp[1] = -100; smp[2] = -40; smp[3] = -30; smp[4] = -20; smp[5] = -10;
        for (int i = 6; i < 14; i++) smp[i] = -100;
        run("t9", 1);
        check("t9 valid c7", obs_v[7], 0);
        check("t9 valid c8", obs_v[8], 1);
        check("t9 energy c8", obs_e[8], 0);
        check("t9 pileup c8", obs_p[8], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
